spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter GUARD_CYCLES, default 2, which sets the number of idle cycles with ss high after each transfer (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 255, which sets the WAIT watchdog limit in clk cycles (8-bit).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports req0 and req1, input, 1 bit each: transfer requests from requester 0 and requester 1.
REQ-006 SHALL have ports data0 and data1, input, 8 bits each: the byte each requester wants to transmit.
REQ-007 SHALL have ports ack0 and ack1, output, 1 bit each: one-cycle pulse meaning the request was accepted and its data latched.
REQ-008 SHALL have ports done0 and done1, output, 1 bit each: one-cycle pulse meaning the granted transfer completed.
REQ-009 SHALL have ports err0 and err1, output, 1 bit each: one-cycle pulse meaning the granted transfer was aborted by the watchdog.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have port spi_data, output, 8 bits: the latched byte presented to the SPI interface.
REQ-012 SHALL have port begin_transmission, output, 1 bit: one-cycle start strobe to the SPI interface.
REQ-013 SHALL have port ss, output, 1 bit: slave select, active-low.
REQ-014 SHALL have port end_transmission, input, 1 bit: transfer-complete indication from the SPI interface.

Function
REQ-015 SHALL implement states IDLE, SETUP, START, WAIT and HOLD, with all outputs registered.
REQ-016 SHALL, in IDLE with at least one reqN high at edge n, enter SETUP at edge n, setting ss=0, latching dataN into spi_data and pulsing ackN for exactly that SETUP cycle.
REQ-017 SHALL resolve simultaneous req0 and req1 round-robin: the requester not granted most recently wins.
REQ-018 SHALL start transfers only in IDLE; a reqN seen outside IDLE waits, and a reqN dropped before grant produces no transfer.
REQ-019 SHALL move from SETUP to START after one cycle; START asserts begin_transmission for exactly one cycle, then moves to WAIT.
REQ-020 SHALL, in WAIT, hold ss=0 and spi_data stable until end_transmission is sampled high, then move to HOLD and pulse doneN of the granted requester in the first HOLD cycle.
REQ-021 SHALL ignore end_transmission in every state except WAIT.
REQ-022 SHALL, in HOLD, drive ss=1 for exactly GUARD_CYCLES cycles, then return to IDLE; a new grant is possible on the edge that leaves HOLD+IDLE, so the minimum gap with ss high equals GUARD_CYCLES.
REQ-023 SHALL update the round-robin pointer on grant, not on completion.
REQ-024 SHALL keep ack, done and err mutually exclusive per cycle and pulse at most one requester at a time.

Reset
REQ-025 SHALL, on rst high at a clock edge, set state=IDLE, ss=1, begin_transmission=0, spi_data=8'h00, all ackN/doneN/errN=0, busy=0, and the pointer so that req0 wins the first tie.
REQ-026 SHALL, on rst mid-transfer, abort it: ss goes high at the next edge and no done or err pulse is produced; rst has priority over every other input.

Configuration
REQ-027 SHALL compile the watchdog only when macro SPI_ARB_TIMEOUT_EN is defined.
REQ-028 SHALL, when SPI_ARB_TIMEOUT_EN is defined, count cycles in WAIT; when the count reaches TIMEOUT without end_transmission, go to HOLD and pulse errN instead of doneN; end_transmission arriving on the same cycle as the timeout counts as success.
REQ-029 SHALL, when SPI_ARB_TIMEOUT_EN is undefined, wait indefinitely in WAIT and tie err0 and err1 to 0.

Verification
REQ-030 SHALL cover a single transfer: req0=1, data0=8'hA5, end_transmission 20 cycles after begin -> ack0 at SETUP, spi_data=A5, one begin pulse, done0 once, ss high for 2 cycles.
REQ-031 SHALL cover a tie: req0 and req1 held high for 3 transfers -> grants in order 0,1,0; data0 and data1 each appear on spi_data in the granted order.
REQ-032 SHALL cover stray input: end_transmission pulsed while in IDLE and in START -> no state change and no done pulse.
REQ-033 SHALL cover reset mid-transfer: rst asserted for 1 cycle in WAIT -> ss=1 and busy=0 next cycle, no done0/done1, next req0 is granted normally.
REQ-034 SHALL cover the watchdog with SPI_ARB_TIMEOUT_EN defined: end_transmission never asserted -> err0 pulse 255 cycles after WAIT entry, then return to IDLE; without the macro -> busy stays high.
REQ-035 SHALL cover back-to-back requests: req1 asserted during the WAIT of req0 -> req1 is granted only after ss has been high for GUARD_CYCLES cycles.

Source files
------------

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter letting two requesters share one byte-wide SPI master.
// Define SPI_ARB_TIMEOUT_EN to build in the WAIT watchdog (err0/err1 are tied low otherwise).
module spi_arbiter #(
   parameter int GUARD_CYCLES = 2,
   parameter int TIMEOUT      = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic       ack0,
   output logic       ack1,
   output logic       done0,
   output logic       done1,
   output logic       err0,
   output logic       err1,
   output logic       busy,
   output logic [7:0] spi_data,
   output logic       begin_transmission,
   output logic       ss,
   input  logic       end_transmission
);
   if (GUARD_CYCLES < 1 || GUARD_CYCLES > 15) begin : g_bad_guard
      $error("spi_arbiter: GUARD_CYCLES must be in 1..15");
   end
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("spi_arbiter: TIMEOUT must be in 1..255");
   end

   typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, HOLD} state_t;

   state_t     state_reg, state_next;
   logic       owner_reg, owner_next;
   logic       last_reg, last_next;
   logic [3:0] hold_cnt_reg, hold_cnt_next;
   logic [7:0] spi_data_reg, spi_data_next;
   logic       ss_reg, ss_next;
   logic       begin_reg, begin_next;
   logic [1:0] ack_reg, ack_next;
   logic [1:0] done_reg, done_next;
   logic       busy_reg;
   logic       pick;
   logic       grant_ok;
`ifdef SPI_ARB_TIMEOUT_EN
   logic [1:0] err_reg, err_next;
   logic [7:0] wait_cnt_reg, wait_cnt_next;
`endif

   always_comb begin
      state_next    = state_reg;
      owner_next    = owner_reg;
      last_next     = last_reg;
      hold_cnt_next = hold_cnt_reg;
      spi_data_next = spi_data_reg;
      ss_next       = ss_reg;
      begin_next    = 1'b0;
      ack_next      = 2'b00;
      done_next     = 2'b00;
`ifdef SPI_ARB_TIMEOUT_EN
      err_next      = 2'b00;
      wait_cnt_next = wait_cnt_reg;
`endif
      // On a tie the requester that did not win last time gets the bus.
      pick     = (req0 && req1) ? ~last_reg : req1;
      grant_ok = (req0 || req1) &&
                 ((state_reg == IDLE) || (state_reg == HOLD && hold_cnt_reg == 4'd0));

      case (state_reg)
         SETUP: begin
            state_next = START;
            begin_next = 1'b1;
         end
         START: begin
            state_next = WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
            wait_cnt_next = 8'd0;
`endif
         end
         WAIT: begin
            if (end_transmission) begin
               state_next           = HOLD;
               ss_next              = 1'b1;
               hold_cnt_next        = 4'(GUARD_CYCLES - 1);
               done_next[owner_reg] = 1'b1;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            else if (wait_cnt_reg == 8'(TIMEOUT - 1)) begin
               state_next          = HOLD;
               ss_next             = 1'b1;
               hold_cnt_next       = 4'(GUARD_CYCLES - 1);
               err_next[owner_reg] = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt_reg + 8'd1;
            end
`endif
         end
         HOLD: begin
            if (hold_cnt_reg == 4'd0)
               state_next = IDLE;
            else
               hold_cnt_next = hold_cnt_reg - 4'd1;
         end
         default: ;
      endcase

      // A grant on the last HOLD edge skips IDLE so the ss-high gap is exactly GUARD_CYCLES.
      if (grant_ok) begin
         state_next     = SETUP;
         ss_next        = 1'b0;
         owner_next     = pick;
         last_next      = pick;
         spi_data_next  = pick ? data1 : data0;
         ack_next[pick] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         owner_reg    <= 1'b0;
         last_reg     <= 1'b1;
         hold_cnt_reg <= 4'd0;
         spi_data_reg <= 8'h00;
         ss_reg       <= 1'b1;
         begin_reg    <= 1'b0;
         ack_reg      <= 2'b00;
         done_reg     <= 2'b00;
         busy_reg     <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
         err_reg      <= 2'b00;
         wait_cnt_reg <= 8'd0;
`endif
      end else begin
         state_reg    <= state_next;
         owner_reg    <= owner_next;
         last_reg     <= last_next;
         hold_cnt_reg <= hold_cnt_next;
         spi_data_reg <= spi_data_next;
         ss_reg       <= ss_next;
         begin_reg    <= begin_next;
         ack_reg      <= ack_next;
         done_reg     <= done_next;
         busy_reg     <= (state_next != IDLE);
`ifdef SPI_ARB_TIMEOUT_EN
         err_reg      <= err_next;
         wait_cnt_reg <= wait_cnt_next;
`endif
      end
   end

   assign ack0               = ack_reg[0];
   assign ack1               = ack_reg[1];
   assign done0              = done_reg[0];
   assign done1              = done_reg[1];
   assign busy               = busy_reg;
   assign spi_data           = spi_data_reg;
   assign begin_transmission = begin_reg;
   assign ss                 = ss_reg;
`ifdef SPI_ARB_TIMEOUT_EN
   assign err0 = err_reg[0];
   assign err1 = err_reg[1];
`else
   assign err0 = 1'b0;
   assign err1 = 1'b0;
`endif

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: per-transfer vector table, corner-case sequences,
// and a random run against a timeline reference model.
module tb_spi_arbiter;
   localparam int GUARD = 2;
   localparam int TMO   = 255;

   logic       clk = 1'b0;
   logic       rst, req0, req1, end_tx;
   logic [7:0] data0, data1;
   logic       ack0, ack1, done0, done1, err0, err1, busy, begin_tx, ss;
   logic [7:0] spi_data;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   spi_arbiter #(.GUARD_CYCLES(GUARD), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
      .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1), .err0(err0), .err1(err1),
      .busy(busy), .spi_data(spi_data), .begin_transmission(begin_tx), .ss(ss),
      .end_transmission(end_tx)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit         q0, q1;
      logic [7:0] d0, d1;
      int         wait_n;
      bit         exp_owner;
      logic [7:0] exp_data;
   } xfer_t;

   // One complete transfer: request, grant, begin strobe, wait, done, guard gap.
   task automatic run_xfer(input xfer_t x);
      bit got;
      int cnt;
      req0 = x.q0; req1 = x.q1; data0 = x.d0; data1 = x.d1;
      got = 0;
      for (int k = 0; k < 40 && !got; k++) begin
         tick();
         got = ack0 | ack1;
      end
      check("ack_seen", 32'(got), 32'd1);
      req0 = 0; req1 = 0;
      if (!got) return;
      check("ack_owner", {ack1, ack0}, x.exp_owner ? 2'b10 : 2'b01);
      check("spi_data_setup", spi_data, x.exp_data);
      check("ss_setup", ss, 1'b0);
      data0 = ~x.d0; data1 = ~x.d1;
      tick(); check("begin_start", {begin_tx, ack0, ack1}, 3'b100);
      tick(); check("begin_once", begin_tx, 1'b0);
      for (int k = 0; k < x.wait_n; k++) begin
         tick();
         check("wait_stable", {done0, done1, err0, err1, ss, spi_data}, {5'b0, x.exp_data});
      end
      end_tx = 1; tick(); end_tx = 0;
      check("done_owner", {done1, done0, err1, err0, ss}, {(x.exp_owner ? 2'b10 : 2'b01), 3'b001});
      cnt = 0;
      while (busy && ss && cnt < 20) begin
         cnt++;
         tick();
      end
      check("guard_len", cnt, GUARD);
      check("idle_after", {busy, ss}, 2'b01);
   endtask

   // Timeline reference model: tracks grant edge and completion edge of the active transfer.
   int         m_t, m_g, m_end;
   bit         m_active, m_owner, m_last, m_err;
   logic [7:0] m_byte;

   task automatic model_edge(input bit r, input bit q0, input bit q1,
                             input logic [7:0] d0, input logic [7:0] d1, input bit et);
      bit free;
      m_t++;
      if (r) begin
         m_active = 0; m_last = 1; m_byte = 8'h00; m_end = -1; m_err = 0;
      end else begin
         free = !m_active || (m_end >= 0 && m_t == m_end + GUARD);
         if (free) begin
            if (q0 || q1) begin
               m_owner  = (q0 && q1) ? !m_last : q1;
               m_last   = m_owner;
               m_byte   = m_owner ? d1 : d0;
               m_active = 1; m_g = m_t; m_end = -1; m_err = 0;
            end else begin
               m_active = 0;
            end
         end else if (m_end < 0 && m_t >= m_g + 3) begin
            if (et) m_end = m_t;
`ifdef SPI_ARB_TIMEOUT_EN
            else if (m_t == m_g + 2 + TMO) begin
               m_end = m_t; m_err = 1;
            end
`endif
         end
      end
   endtask

   function automatic logic [16:0] model_out();
      bit a, fin;
      a   = m_active && m_t == m_g;
      fin = m_active && m_end == m_t;
      return {a && !m_owner, a && m_owner,
              fin && !m_err && !m_owner, fin && !m_err && m_owner,
              fin && m_err && !m_owner, fin && m_err && m_owner,
              m_active, m_active && m_t == m_g + 1, !(m_active && m_end < 0), m_byte};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "global timeout");
   end

   initial begin
      xfer_t tbl[9];
      int    cnt;
      bit    got;
      tbl[0] = '{1, 1, 8'h11, 8'h22, 3,  0, 8'h11};
      tbl[1] = '{1, 1, 8'h33, 8'h44, 0,  1, 8'h44};
      tbl[2] = '{1, 1, 8'h55, 8'h66, 1,  0, 8'h55};
      tbl[3] = '{1, 0, 8'hA5, 8'h00, 19, 0, 8'hA5};
      tbl[4] = '{0, 1, 8'h00, 8'h3C, 2,  1, 8'h3C};
      tbl[5] = '{0, 1, 8'h00, 8'h5A, 4,  1, 8'h5A};
      tbl[6] = '{1, 1, 8'h0F, 8'hF0, 0,  0, 8'h0F};
      tbl[7] = '{1, 0, 8'hC3, 8'h00, 2,  0, 8'hC3};
      tbl[8] = '{1, 1, 8'h81, 8'h18, 1,  1, 8'h18};

      // Reset must win over a pending request.
      rst = 1; req0 = 1; req1 = 0; data0 = 8'h77; data1 = 8'h00; end_tx = 0;
      tick(); tick();
      check("reset_outputs", {ack0, ack1, done0, done1, err0, err1, busy, begin_tx, ss, spi_data},
            {9'b000000001, 8'h00});
      req0 = 0; rst = 0;
      tick();

      foreach (tbl[i]) run_xfer(tbl[i]);

      // Stray end_transmission in IDLE and in START.
      end_tx = 1; tick(); end_tx = 0;
      check("stray_idle", {busy, done0, done1, ss}, 4'b0001);
      tick();
      check("stray_idle2", {busy, done0, done1, ss}, 4'b0001);
      req0 = 1; data0 = 8'h96; tick(); req0 = 0;
      check("stray_ack", {ack0, spi_data}, {1'b1, 8'h96});
      tick();
      end_tx = 1; tick(); end_tx = 0;
      check("stray_start", {busy, done0, done1, ss, begin_tx}, 5'b10000);
      tick();
      check("stray_start2", {busy, done0, done1, ss}, 4'b1000);
      end_tx = 1; tick(); end_tx = 0;
      check("stray_done", {done0, ss}, 2'b11);
      repeat (GUARD) tick();
      check("stray_idle_after", busy, 1'b0);

      // Reset in WAIT aborts silently and resets the tie pointer.
      req0 = 1; data0 = 8'h4D; tick(); req0 = 0;
      check("rst_ack", ack0, 1'b1);
      tick(); tick(); tick();
      rst = 1; tick(); rst = 0;
      check("rst_abort", {ss, busy, done0, done1}, 4'b1000);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("rst_quiet", {busy, done0, done1, err0, err1}, 5'b0);
      end
      run_xfer('{1, 1, 8'hE1, 8'h1E, 2, 0, 8'hE1});

      // req1 raised during req0's WAIT waits out the full guard gap.
      req0 = 1; data0 = 8'hB2; tick(); req0 = 0;
      check("b2b_ack0", ack0, 1'b1);
      tick(); tick();
      req1 = 1; data1 = 8'h2B; tick();
      check("b2b_no_early", {ack1, busy, ss}, 3'b010);
      end_tx = 1; tick(); end_tx = 0;
      check("b2b_done0", {done0, ss}, 2'b11);
      cnt = 0;
      while (ss && !ack1 && cnt < 20) begin
         cnt++;
         tick();
      end
      req1 = 0;
      check("b2b_gap", cnt, GUARD);
      check("b2b_ack1", {ack1, ss, spi_data}, {2'b10, 8'h2B});
      tick(); tick();
      end_tx = 1; tick(); end_tx = 0;
      check("b2b_done1", {done1, done0}, 2'b10);
      repeat (GUARD) tick();
      check("b2b_idle", busy, 1'b0);

      // Watchdog.
      req0 = 1; data0 = 8'h3E; tick(); req0 = 0;
      tick(); tick();
`ifdef SPI_ARB_TIMEOUT_EN
      cnt = 0; got = 0;
      while (!got && cnt < TMO + 20) begin
         tick();
         cnt++;
         got = err0 | err1 | done0 | done1;
      end
      check("wd_latency", cnt, TMO);
      check("wd_err0", {err0, err1, done0, done1, ss}, 5'b10001);
      repeat (GUARD) tick();
      check("wd_idle", busy, 1'b0);
`else
      got = 0;
      for (int k = 0; k < TMO + 40; k++) begin
         tick();
         got = got | err0 | err1 | done0 | done1 | ~busy;
      end
      check("wd_disabled_stuck", {busy, ss, got}, 3'b100);
      rst = 1; tick(); rst = 0;
      check("wd_disabled_rst", busy, 1'b0);
`endif

      // Random run against the reference model.
      m_t = 0; m_g = 0; m_end = -1; m_active = 0; m_owner = 0; m_last = 1; m_err = 0;
      m_byte = 8'h00;
      for (int i = 0; i < 3000; i++) begin
         rst    = (i == 0) || ($urandom_range(0, 199) == 0);
         req0   = ($urandom_range(0, 2) == 0);
         req1   = ($urandom_range(0, 2) == 0);
         data0  = 8'($urandom);
         data1  = 8'($urandom);
         end_tx = ($urandom_range(0, 5) == 0);
         @(posedge clk);
         model_edge(rst, req0, req1, data0, data1, end_tx);
         #1;
         check("random", {ack0, ack1, done0, done1, err0, err1, busy, begin_tx, ss, spi_data},
               model_out());
      end
      rst = 0; req0 = 0; req1 = 0; end_tx = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
